mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8: max cycles a memory state waits for mem_ready; 0 disables the timeout.
REQ-002 SHALL have parameter TOW, default 4: timeout counter width; TIMEOUT SHALL fit in TOW bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port opcode, input, 6: instruction bits [31:26].
REQ-006 SHALL have port func, input, 6: instruction bits [5:0].
REQ-007 SHALL have port mem_ready, input, 1: memory completed the current read/write this cycle.
REQ-008 SHALL have ports PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, output, 1 each: datapath strobes/selects; PCWriteCondN = branch-if-not-equal.
REQ-009 SHALL have ports PCSource, ALUSrcB, ALUOp, RegDst, MemtoReg, output, 2 each: RegDst 00=rt, 01=rd, 10=r31; MemtoReg 00=ALUOut, 01=MDR, 10=PC; PCSource 00=ALU, 01=ALUOut, 10=jump target, 11=rs register.
REQ-010 SHALL have port curr_state, output, 4: state encoding.
REQ-011 SHALL have port err, output, 1: sticky error flag.

Function
REQ-012 SHALL implement states and encodings: FETCH 0, DECODE 1, MADDR 2, MEMLW 3, MEMR 4, MEMSW 5, EXEC 6, RCOMP 7, BRANCH 8, JUMP 9, IMM A, JR B, JAL C, ERR E, INIT F; curr_state SHALL equal the encoding.
REQ-013 SHALL decode in DECODE: LW/SW (100011/101011) and ADDI/ANDI/ORI (001000/001100/001101) -> MADDR; R (000000) -> EXEC; BEQ (000100)/BNE (000101) -> BRANCH; J (000010) -> JUMP; JAL (000011) -> JAL; any other -> ERR.
REQ-014 SHALL transition: INIT->FETCH; MADDR->MEMLW (LW), MEMSW (SW), IMM (ADDI/ANDI/ORI); EXEC->JR if func=001000, else RCOMP; MEMLW->MEMR; MEMR, MEMSW, RCOMP, BRANCH, JUMP, IMM, JR, JAL->FETCH; ERR->ERR.
REQ-015 SHALL hold FETCH, MEMLW and MEMSW while mem_ready=0 and leave only on a cycle with mem_ready=1.
REQ-016 SHALL assert MemRead in FETCH and MEMLW, and MemWrite in MEMSW, on every cycle of the state including wait cycles.
REQ-017 SHALL assert IRWrite and PCWrite in FETCH only on the cycle mem_ready=1 (ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00).
REQ-018 SHALL drive DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; MADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; MEMLW/MEMSW: IorD=1.
REQ-019 SHALL drive MEMR: RegWrite=1, MemtoReg=01, RegDst=00; RCOMP: RegWrite=1, RegDst=01, MemtoReg=00, ALUOp=10.
REQ-020 SHALL drive IMM: RegWrite=1, RegDst=00, ALUSrcA=1, ALUSrcB=10; ALUOp=00 for ADDI, 11 for ANDI/ORI (ALU decodes opcode).
REQ-021 SHALL drive BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01; PCWriteCond=1 for BEQ, PCWriteCondN=1 for BNE, never both.
REQ-022 SHALL drive JUMP: PCWrite=1, PCSource=10; JR: PCWrite=1, PCSource=11; JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10.
REQ-023 SHALL hold every output not named for a state at 0 in that state, including INIT and ERR.
REQ-024 SHALL count wait cycles with mem_ready=0 in FETCH/MEMLW/MEMSW; counter cleared on state entry and on mem_ready=1; when TIMEOUT!=0 and the count reaches TIMEOUT, next state SHALL be ERR.
REQ-025 SHALL set err=1 on the cycle after entering ERR (registered) and hold it until reset; ERR asserts no strobes.
REQ-026 SHALL give mem_ready=1 priority over timeout if both occur in the same cycle.

Reset
REQ-027 SHALL on rst=1 at a clock edge enter INIT, clear the wait counter and err, regardless of current state, including mid-wait or ERR.
REQ-028 SHALL in INIT drive all strobes 0, all 2-bit selects 00, curr_state=F, err=0.

Configuration
REQ-029 SHALL, with MC_JAL_EN defined, implement JAL state and decode per REQ-013/REQ-022.
REQ-030 SHALL, with MC_JAL_EN undefined, decode opcode 000011 to ERR, never reach state C, and hold RegDst<=01 and MemtoReg<=01.

Verification
REQ-031 SHALL check: reset, LW with mem_ready tied 1 -> states F,0,1,2,3,4,0; RegWrite=1 and MemtoReg=01 only in state 4.
REQ-032 SHALL check: FETCH with mem_ready low 3 cycles then high -> MemRead=1 for 4 cycles, IRWrite/PCWrite=1 only on the 4th.
REQ-033 SHALL check: TIMEOUT=8, mem_ready held 0 in MEMSW -> ERR after 8 wait cycles, err=1, stays until rst=1 then INIT.
REQ-034 SHALL check: BNE -> BRANCH with PCWriteCondN=1, PCWriteCond=0; R func=001000 -> JR with PCWrite=1, PCSource=11.
REQ-035 SHALL check: opcode 111111 in DECODE -> ERR; with MC_JAL_EN, opcode 000011 -> JAL with RegDst=10, MemtoReg=10.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle datapath control FSM with mem_ready handshaking and wait timeout.
// Define MC_JAL_EN to enable the JAL state; otherwise opcode 000011 decodes to ERR.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | read instruction memory, write IR and PC+4 on mem_ready
// DECODE | decode opcode, precompute branch target in ALUOut
// MADDR  | compute memory address / immediate operand
// MEMLW  | read data memory, wait on mem_ready
// MEMR   | write loaded word (MDR) into rt
// MEMSW  | write data memory, wait on mem_ready
// EXEC   | R-type execute cycle
// RCOMP  | write R-type result into rd
// BRANCH | compare and conditionally update PC
// JUMP   | load jump target into PC
// IMM    | write immediate-ALU result into rt
// JR     | load rs into PC
// JAL    | load jump target into PC, link PC into r31
// ERR    | illegal opcode or memory timeout, sticky until reset
// INIT   | post-reset idle cycle
module mc_control_fsm #(
  parameter int TIMEOUT = 8,
  parameter int TOW     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondN,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [3:0] curr_state,
  output logic       err
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'h0,
    S_DECODE = 4'h1,
    S_MADDR  = 4'h2,
    S_MEMLW  = 4'h3,
    S_MEMR   = 4'h4,
    S_MEMSW  = 4'h5,
    S_EXEC   = 4'h6,
    S_RCOMP  = 4'h7,
    S_BRANCH = 4'h8,
    S_JUMP   = 4'h9,
    S_IMM    = 4'hA,
    S_JR     = 4'hB,
`ifdef MC_JAL_EN
    S_JAL    = 4'hC,
`endif
    S_ERR    = 4'hE,
    S_INIT   = 4'hF
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Count value on the last tolerated wait cycle; reaching it with mem_ready low times out.
  localparam logic [TOW-1:0] TO_LAST = (TIMEOUT > 0) ? TOW'(TIMEOUT - 1) : '0;

  state_t         state;
  state_t         next_state;
  logic [TOW-1:0] wait_cnt;
  logic           in_wait;
  logic           timeout_hit;

  assign in_wait     = (state == S_FETCH) || (state == S_MEMLW) || (state == S_MEMSW);
  assign timeout_hit = (TIMEOUT != 0) && in_wait && !mem_ready && (wait_cnt == TO_LAST);
  assign curr_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Cleared on entry and on every completed access; saturates when timeout is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!in_wait || mem_ready || (next_state != state)) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == S_ERR) begin
      err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT: next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        next_state = S_DECODE;
        else if (timeout_hit) next_state = S_ERR;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI: next_state = S_MADDR;
          OP_R:                                   next_state = S_EXEC;
          OP_BEQ, OP_BNE:                         next_state = S_BRANCH;
          OP_J:                                   next_state = S_JUMP;
`ifdef MC_JAL_EN
          OP_JAL:                                 next_state = S_JAL;
`else
          OP_JAL:                                 next_state = S_ERR;
`endif
          default:                                next_state = S_ERR;
        endcase
      end
      S_MADDR: begin
        case (opcode)
          OP_LW:                   next_state = S_MEMLW;
          OP_SW:                   next_state = S_MEMSW;
          OP_ADDI, OP_ANDI, OP_ORI: next_state = S_IMM;
          default:                 next_state = S_ERR;
        endcase
      end
      S_MEMLW: begin
        if (mem_ready)        next_state = S_MEMR;
        else if (timeout_hit) next_state = S_ERR;
      end
      S_MEMSW: begin
        if (mem_ready)        next_state = S_FETCH;
        else if (timeout_hit) next_state = S_ERR;
      end
      S_EXEC: next_state = (func == FN_JR) ? S_JR : S_RCOMP;
      S_MEMR, S_RCOMP, S_BRANCH, S_JUMP, S_IMM, S_JR: next_state = S_FETCH;
`ifdef MC_JAL_EN
      S_JAL: next_state = S_FETCH;
`endif
      S_ERR:   next_state = S_ERR;
      default: next_state = S_ERR;
    endcase
  end

  always_comb begin
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    PCWriteCondN = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    PCSource     = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    RegDst       = 2'b00;
    MemtoReg     = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMLW: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMSW: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEMR: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_RCOMP: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        ALUOp    = 2'b10;
      end
      S_IMM: begin
        RegWrite = 1'b1;
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        // ANDI/ORI: the ALU decoder picks the logic op from the opcode itself.
        ALUOp    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUOp        = 2'b01;
        PCSource     = 2'b01;
        PCWriteCond  = (opcode == OP_BEQ);
        PCWriteCondN = (opcode == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-instruction state walks are queued
// as expected per-cycle records and checked by an independent negedge monitor.
module tb_mc_control_fsm;

  localparam int TIMEOUT = 8;
  localparam int TOW     = 4;
`ifdef MC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  localparam logic [3:0] ST_FETCH = 4'h0, ST_DECODE = 4'h1, ST_MADDR = 4'h2, ST_MEMLW = 4'h3;
  localparam logic [3:0] ST_MEMR = 4'h4, ST_MEMSW = 4'h5, ST_EXEC = 4'h6, ST_RCOMP = 4'h7;
  localparam logic [3:0] ST_BRANCH = 4'h8, ST_JUMP = 4'h9, ST_IMM = 4'hA, ST_JR = 4'hB;
  localparam logic [3:0] ST_JAL = 4'hC, ST_ERR = 4'hE, ST_INIT = 4'hF;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, FN_JR = 6'b001000;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] PCSource, ALUSrcB, ALUOp, RegDst, MemtoReg;
  logic [3:0] curr_state;
  logic       err;

  mc_control_fsm #(.TIMEOUT(TIMEOUT), .TOW(TOW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondN(PCWriteCondN),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .curr_state(curr_state), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, pcwcn, iord, mrd, mwr, irw, rw, asa;
    logic [1:0] pcs, asb, aop, rdst, m2r;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int   errors = 0;
  int   checks = 0;
  bit   prev_err;

  // Output table for one cycle of a given state, straight from the datapath control rules.
  function automatic exp_t spec_of(input logic [3:0] st, input logic [5:0] op,
                                   input logic mr, input bit e_err);
    exp_t e;
    e = '0;
    e.st  = st;
    e.err = e_err;
    case (st)
      ST_FETCH:  begin e.mrd = 1'b1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
      ST_DECODE: e.asb = 2'b11;
      ST_MADDR:  begin e.asa = 1'b1; e.asb = 2'b10; end
      ST_MEMLW:  begin e.mrd = 1'b1; e.iord = 1'b1; end
      ST_MEMSW:  begin e.mwr = 1'b1; e.iord = 1'b1; end
      ST_MEMR:   begin e.rw = 1'b1; e.m2r = 2'b01; end
      ST_RCOMP:  begin e.rw = 1'b1; e.rdst = 2'b01; e.aop = 2'b10; end
      ST_IMM: begin
        e.rw = 1'b1; e.asa = 1'b1; e.asb = 2'b10;
        e.aop = (op == OP_ADDI) ? 2'b00 : 2'b11;
      end
      ST_BRANCH: begin
        e.asa = 1'b1; e.aop = 2'b01; e.pcs = 2'b01;
        e.pcwc = (op == OP_BEQ); e.pcwcn = (op == OP_BNE);
      end
      ST_JUMP: begin e.pcw = 1'b1; e.pcs = 2'b10; end
      ST_JR:   begin e.pcw = 1'b1; e.pcs = 2'b11; end
      ST_JAL:  begin e.pcw = 1'b1; e.pcs = 2'b10; e.rw = 1'b1; e.rdst = 2'b10; e.m2r = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int rand_wait();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(6, 9));
    return int'($urandom_range(0, 3));
  endfunction

  // One clock cycle spent in state st with mem_ready=mr; called just after a rising edge.
  task automatic cyc(input logic [3:0] st, input logic mr);
    mem_ready = mr;
    exp_q.push_back(spec_of(st, opcode, mr, prev_err));
    prev_err = (st == ST_ERR);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit known, input logic [3:0] st);
    rst = 1'b1;
    mem_ready = rbit();
    if (known) begin
      exp_q.push_back(spec_of(st, opcode, mem_ready, prev_err));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_err = 1'b0;
    cyc(ST_INIT, rbit());
  endtask

  // w cycles with mem_ready low, then one with it high, unless the timeout fires first.
  task automatic wait_phase(input logic [3:0] st, input int w, output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; i < w; i++) begin
      cyc(st, 1'b0);
      if (TIMEOUT != 0 && i + 1 == TIMEOUT) begin
        timed_out = 1'b1;
        return;
      end
    end
    cyc(st, 1'b1);
  endtask

  task automatic err_tail();
    int n;
    n = int'($urandom_range(1, 3));
    for (int i = 0; i < n; i++) cyc(ST_ERR, rbit());
    do_reset(1'b1, ST_ERR);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
    bit to;
    opcode = op;
    func   = fn;
    wait_phase(ST_FETCH, wf, to);
    if (to) begin
      err_tail();
      return;
    end
    cyc(ST_DECODE, rbit());
    case (op)
      OP_LW: begin
        cyc(ST_MADDR, rbit());
        wait_phase(ST_MEMLW, wm, to);
        if (to) err_tail();
        else cyc(ST_MEMR, rbit());
      end
      OP_SW: begin
        cyc(ST_MADDR, rbit());
        wait_phase(ST_MEMSW, wm, to);
        if (to) err_tail();
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        cyc(ST_MADDR, rbit());
        cyc(ST_IMM, rbit());
      end
      OP_R: begin
        cyc(ST_EXEC, rbit());
        cyc((fn == FN_JR) ? ST_JR : ST_RCOMP, rbit());
      end
      OP_BEQ, OP_BNE: cyc(ST_BRANCH, rbit());
      OP_J:           cyc(ST_JUMP, rbit());
      OP_JAL: begin
        if (JAL_EN) cyc(ST_JAL, rbit());
        else err_tail();
      end
      default: err_tail();
    endcase
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {curr_state, PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite,
               IRWrite, RegWrite, ALUSrcA, PCSource, ALUSrcB, ALUOp, RegDst, MemtoReg, err};
      checks++;
      if (mon_a.st !== mon_e.st) begin
        errors++;
        $display("FAIL state @%0t: got %h want %h", $time, mon_a.st, mon_e.st);
      end
      checks++;
      if (mon_a[19:0] !== mon_e[19:0]) begin
        errors++;
        $display("FAIL outputs @%0t st=%h: got %h want %h", $time, mon_e.st, mon_a[19:0], mon_e[19:0]);
      end
    end
  end

  logic [5:0] op_tab [11];
  logic [5:0] r_op, r_fn;

  initial begin
    rst = 1'b1;
    opcode = 6'd0;
    func = 6'd0;
    mem_ready = 1'b0;
    prev_err = 1'b0;
    op_tab = '{OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_R, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_R};

    do_reset(1'b0, ST_INIT);
    run_instr(OP_LW, 6'd0, 0, 0);
    run_instr(OP_LW, 6'd0, 3, 2);
    run_instr(OP_SW, 6'd0, 0, TIMEOUT);
    run_instr(OP_BNE, 6'd0, 1, 0);
    run_instr(OP_BEQ, 6'd0, 0, 0);
    run_instr(OP_R, FN_JR, 0, 0);
    run_instr(OP_R, 6'b100000, 2, 0);
    run_instr(6'b111111, 6'd0, 0, 0);
    run_instr(OP_JAL, 6'd0, 0, 0);
    run_instr(OP_ADDI, 6'd0, 0, 0);
    run_instr(OP_ANDI, 6'd0, 0, 0);
    run_instr(OP_ORI, 6'd0, 0, 0);
    run_instr(OP_J, 6'd0, 0, 0);
    run_instr(OP_SW, 6'd0, TIMEOUT - 1, TIMEOUT - 1);
    run_instr(OP_LW, 6'd0, TIMEOUT, 0);

    opcode = OP_LW;
    cyc(ST_FETCH, 1'b0);
    cyc(ST_FETCH, 1'b0);
    cyc(ST_FETCH, 1'b0);
    do_reset(1'b1, ST_FETCH);
    run_instr(OP_LW, 6'd0, TIMEOUT - 1, TIMEOUT - 1);

    for (int k = 0; k < 300; k++) begin
      int idx;
      idx = int'($urandom_range(0, 11));
      r_op = (idx == 11) ? 6'($urandom) : op_tab[idx];
      r_fn = rbit() ? FN_JR : 6'($urandom);
      run_instr(r_op, r_fn, rand_wait(), rand_wait());
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
